cpumc_hs: RTL and testbench
===========================

// Module: cpumc_hs
//
// PURPOSE
// Parametrised, handshaked CPU memory controller for the NES CPU address space. It serves
// request/ack transactions from the CPU or ROM loader into internal block RAM (WRAM, optional
// SRAM, PRG-ROM) and forwards the 0x2000-0x401F I/O range to an external register port with
// wait states and timeout. It replaces the combinational controller with a registered-response design.
//
// PARAMETERS
// RAM_ADDR_WIDTH  11     WRAM index width; 0x0000-0x1FFF mirrors every 2^RAM_ADDR_WIDTH bytes
// PRG_BANKS       2      16KB PRG-ROM banks (1 or 2); with 1, 0xC000-0xFFFF mirrors 0x8000-0xBFFF
// SRAM_EN         0      1: 8KB SRAM instantiated at 0x6000-0x7FFF; 0: that range is invalid
// IO_TIMEOUT      15     max IO_WAIT cycles before abort; 0 disables timeout
// INVALID_DATA    8'hCD  dout value returned on invalid or aborted requests
//
// PORTS
// clk          in   1   system clock
// rst          in   1   synchronous reset, active-high
// req          in   1   request strobe, sampled only when busy=0
// wr           in   1   1=write, 0=read; qualified by req
// addr         in   16  CPU address; qualified by req
// din          in   8   write data; qualified by req
// dout         out  8   read data, valid when ack=1, held until next ack
// ack          out  1   one-cycle completion pulse
// invalid_req  out  1   one-cycle pulse with ack: unmapped address or I/O timeout
// busy         out  1   transaction in flight; req ignored while 1
// io_sel       out  1   I/O access active; held until io_ack or timeout
// io_wr        out  1   I/O write qualifier, valid while io_sel=1
// io_addr      out  16  latched I/O address, valid while io_sel=1
// io_wdata     out  8   latched I/O write data, valid while io_sel=1
// io_rdata     in   8   I/O read data, sampled in the io_ack cycle
// io_ack       in   1   I/O completion from register block
//
// BEHAVIOUR
// - Reset: state=IDLE; dout=0, ack=0, invalid_req=0, busy=0, io_sel=0, io_wr=0, io_addr=0,
//   io_wdata=0. Memory contents are not cleared.
// - States IDLE, MEM, IO_WAIT. busy = (state != IDLE). Request accepted when req=1 in IDLE;
//   addr/wr/din latched at that edge. Requests while busy are dropped (no queue).
// - Decode of latched addr:
//   0x0000-0x1FFF WRAM, index addr[RAM_ADDR_WIDTH-1:0]
//   0x2000-0x401F I/O port
//   0x6000-0x7FFF SRAM, index addr[12:0], only if SRAM_EN=1
//   0x8000-0xFFFF PRG-ROM, index addr[14:0] (PRG_BANKS=2) or addr[13:0] (PRG_BANKS=1)
//   anything else: invalid
// - PRG-ROM is writable through this port (loader path); no write protection.
// - Memory (req accepted in cycle N): cycle N+1 state MEM drives RAM addr, we=wr; cycle N+2 state
//   IDLE with ack=1, dout=RAM data (read) or unchanged (write). Exactly one RAM is written, once.
// - Invalid (cycle N): no RAM/I/O activity; cycle N+1 ack=1, invalid_req=1, dout=INVALID_DATA.
// - I/O: from N+1 state IO_WAIT, io_sel=1, io_wr/io_addr/io_wdata stable. If io_ack=1 in cycle M:
//   io_sel=0 at M+1, ack=1 at M+1, dout=io_rdata(M) on reads, unchanged on writes. io_ack outside
//   IO_WAIT ignored. If IO_TIMEOUT>0 and IO_WAIT lasts IO_TIMEOUT cycles without io_ack: abort;
//   next cycle io_sel=0, ack=1, invalid_req=1, dout=INVALID_DATA. io_ack in the final
//   (IO_TIMEOUT-th) cycle wins over timeout.
// - ack is asserted in IDLE, so a req in the ack cycle is accepted (back-to-back, 2-cycle mem throughput).
// - Reset mid-transaction: next cycle IDLE, io_sel=0, no ack; a write in MEM at the reset edge
//   is suppressed (we gated by !rst).
//
// TESTING
// 1. Write 0x0005<=0x3C, then read 0x0805 and 0x1805 -> each ack 2 cycles after req, dout=0x3C.
// 2. PRG_BANKS=1: write 0x8123<=0xA5, read 0xC123 -> 0xA5; PRG_BANKS=2: read 0xC123 unaffected.
// 3. Read 0x5000 and write 0x4500 (SRAM_EN=0 also 0x6000) -> ack+invalid_req 1 cycle after req,
//    dout=0xCD, no memory changed (verify by readback).
// 4. I/O read 0x2002, io_ack after 3 IO_WAIT cycles with io_rdata=0x80 -> ack next cycle,
//    dout=0x80, io_sel high exactly 3 cycles; req during busy dropped.
// 5. I/O write 0x4016, io_ack never -> io_sel high 15 cycles, then ack+invalid_req, dout=0xCD.
// 6. Reset asserted in MEM of write 0x0010<=0x55 and in IO_WAIT -> no ack, io_sel=0 next cycle,
//    readback 0x0010 shows old value; back-to-back reads in ack cycles complete every 2 cycles.

Source files
------------

// File: rtl/cpumc_hs.sv
// Handshaked NES CPU memory controller: WRAM, optional SRAM, PRG-ROM and an external I/O register port.
// Memory ack 2 cycles after req, unmapped ack 1 cycle after, I/O on io_ack or timeout; req ignored while busy.
module cpumc_hs #(
   parameter int         RAM_ADDR_WIDTH = 11,
   parameter int         PRG_BANKS      = 2,
   parameter int         SRAM_EN        = 0,
   parameter int         IO_TIMEOUT     = 15,
   parameter logic [7:0] INVALID_DATA   = 8'hCD
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req,
   input  logic        i_wr,
   input  logic [15:0] i_addr,
   input  logic [7:0]  i_din,
   output logic [7:0]  o_dout,
   output logic        o_ack,
   output logic        o_invalid_req,
   output logic        o_busy,
   output logic        o_io_sel,
   output logic        o_io_wr,
   output logic [15:0] o_io_addr,
   output logic [7:0]  o_io_wdata,
   input  logic [7:0]  i_io_rdata,
   input  logic        i_io_ack
);
   localparam int            PRG_AW = (PRG_BANKS == 2) ? 15 : 14;
   localparam int            TW     = $clog2(IO_TIMEOUT + 1) + 1;
   localparam logic [TW-1:0] T_LAST = TW'(IO_TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_MEM, S_IO_WAIT} state_t;
   typedef enum logic [2:0] {R_WRAM, R_IO, R_SRAM, R_PRG, R_INV} region_t;

   function automatic region_t f_decode(input logic [15:0] a);
      region_t r;
      if (a < 16'h2000)                        r = R_WRAM;
      else if (a <= 16'h401F)                  r = R_IO;
      else if (a >= 16'h6000 && a < 16'h8000)  r = (SRAM_EN != 0) ? R_SRAM : R_INV;
      else if (a[15])                          r = R_PRG;
      else                                     r = R_INV;
      return r;
   endfunction

   state_t        r_state;
   state_t        w_next_state;
   region_t       r_region;
   region_t       w_region;
   logic [14:0]   r_idx;
   logic          r_wr;
   logic [7:0]    r_din;
   logic [7:0]    r_dout;
   logic          r_ack;
   logic          r_inv;
   logic          r_io_wr;
   logic [15:0]   r_io_addr;
   logic [7:0]    r_io_wdata;
   logic [TW-1:0] r_tcnt;
   logic          w_accept;
   logic          w_done_mem;
   logic          w_done_io;
   logic          w_abort;
   logic          w_inv_now;
   logic          w_tmo;
   logic          w_we;
   logic [7:0]    w_mem_rdata;
   logic [7:0]    w_sram_rdata;

   logic [7:0] r_wram [0:(1<<RAM_ADDR_WIDTH)-1];
   logic [7:0] r_prg  [0:(1<<PRG_AW)-1];

   assign w_region = f_decode(i_addr);
   assign w_accept = (r_state == S_IDLE) && i_req;
   assign w_tmo    = (IO_TIMEOUT > 0) && (r_tcnt == T_LAST);
   // A reset arriving on the MEM edge must not leave a half-finished write behind.
   assign w_we     = (r_state == S_MEM) && r_wr && !i_rst;

   always_comb begin
      w_next_state = r_state;
      w_done_mem   = 1'b0;
      w_done_io    = 1'b0;
      w_abort      = 1'b0;
      w_inv_now    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_req) begin
               case (w_region)
                  R_WRAM, R_SRAM, R_PRG: w_next_state = S_MEM;
                  R_IO:                  w_next_state = S_IO_WAIT;
                  default:               w_inv_now    = 1'b1;
               endcase
            end
         end
         S_MEM: begin
            w_next_state = S_IDLE;
            w_done_mem   = 1'b1;
         end
         S_IO_WAIT: begin
            if (i_io_ack) begin
               w_next_state = S_IDLE;
               w_done_io    = 1'b1;
            end else if (w_tmo) begin
               w_next_state = S_IDLE;
               w_abort      = 1'b1;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_region   <= R_INV;
         r_idx      <= '0;
         r_wr       <= 1'b0;
         r_din      <= '0;
         r_dout     <= '0;
         r_ack      <= 1'b0;
         r_inv      <= 1'b0;
         r_io_wr    <= 1'b0;
         r_io_addr  <= '0;
         r_io_wdata <= '0;
         r_tcnt     <= '0;
      end else begin
         r_state <= w_next_state;
         r_ack   <= w_done_mem || w_done_io || w_abort || w_inv_now;
         r_inv   <= w_abort || w_inv_now;
         if (w_accept) begin
            r_region <= w_region;
            r_idx    <= i_addr[14:0];
            r_wr     <= i_wr;
            r_din    <= i_din;
            r_tcnt   <= '0;
            if (w_region == R_IO) begin
               r_io_wr    <= i_wr;
               r_io_addr  <= i_addr;
               r_io_wdata <= i_din;
            end
         end else if (r_state == S_IO_WAIT) begin
            r_tcnt <= r_tcnt + 1'b1;
         end
         if (w_inv_now || w_abort)       r_dout <= INVALID_DATA;
         else if (w_done_mem && !r_wr)   r_dout <= w_mem_rdata;
         else if (w_done_io && !r_wr)    r_dout <= i_io_rdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_we && r_region == R_WRAM) r_wram[r_idx[RAM_ADDR_WIDTH-1:0]] <= r_din;
   end

   always_ff @(posedge i_clk) begin
      if (w_we && r_region == R_PRG) r_prg[r_idx[PRG_AW-1:0]] <= r_din;
   end

   generate
      if (SRAM_EN != 0) begin : g_sram
         logic [7:0] r_sram [0:8191];
         always_ff @(posedge i_clk) begin
            if (w_we && r_region == R_SRAM) r_sram[r_idx[12:0]] <= r_din;
         end
         assign w_sram_rdata = r_sram[r_idx[12:0]];
      end else begin : g_no_sram
         assign w_sram_rdata = 8'h00;
      end
   endgenerate

   always_comb begin
      w_mem_rdata = 8'h00;
      case (r_region)
         R_WRAM:  w_mem_rdata = r_wram[r_idx[RAM_ADDR_WIDTH-1:0]];
         R_SRAM:  w_mem_rdata = w_sram_rdata;
         R_PRG:   w_mem_rdata = r_prg[r_idx[PRG_AW-1:0]];
         default: w_mem_rdata = 8'h00;
      endcase
   end

   assign o_dout        = r_dout;
   assign o_ack         = r_ack;
   assign o_invalid_req = r_inv;
   assign o_busy        = (r_state != S_IDLE);
   assign o_io_sel      = (r_state == S_IO_WAIT);
   assign o_io_wr       = r_io_wr;
   assign o_io_addr     = r_io_addr;
   assign o_io_wdata    = r_io_wdata;
endmodule

// File: tb/tb_cpumc_hs.sv
// Bench for cpumc_hs: transaction-level model predicts per-cycle outputs; directed cases plus random traffic.
module tb_cpumc_hs;
   localparam int         RAW     = 11;
   localparam int         BANKS   = 2;
   localparam int         SRAM    = 0;
   localparam int         TMO     = 15;
   localparam logic [7:0] INV_D   = 8'hCD;

   logic        clk = 1'b0;
   logic        rst, req, wr, ack, invalid_req, busy, io_sel, io_wr, io_ack;
   logic [15:0] addr, io_addr;
   logic [7:0]  din, dout, io_wdata, io_rdata;

   cpumc_hs #(.RAM_ADDR_WIDTH(RAW), .PRG_BANKS(BANKS), .SRAM_EN(SRAM),
              .IO_TIMEOUT(TMO), .INVALID_DATA(INV_D)) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_wr(wr), .i_addr(addr), .i_din(din),
      .o_dout(dout), .o_ack(ack), .o_invalid_req(invalid_req), .o_busy(busy),
      .o_io_sel(io_sel), .o_io_wr(io_wr), .o_io_addr(io_addr), .o_io_wdata(io_wdata),
      .i_io_rdata(io_rdata), .i_io_ack(io_ack));

   always #5 clk = ~clk;

   typedef struct {
      int          t_acc;
      int          t_ack;
      bit          ack_exp;
      bit          inv;
      bit          io;
      bit          wr;
      logic [15:0] addr;
      logic [7:0]  wd;
      logic [7:0]  dout_before;
      logic [7:0]  dout_after;
   } txn_t;

   int         cyc = 0;
   int         n_chk = 0;
   int         n_pass = 0;
   int         iosel_cnt = 0;
   int         cur = -1;
   bit         chk_on = 1'b0;
   txn_t       tq[$];
   logic [7:0] mmem [int];
   logic [7:0] last_dout = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (io_sel === 1'b1) iosel_cnt = iosel_cnt + 1;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk = n_chk + 1;
      if (act === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // 0 WRAM, 1 I/O, 2 SRAM, 3 PRG, 4 unmapped
   function automatic int region(input logic [15:0] a);
      if (a < 16'h2000) return 0;
      if (a <= 16'h401F) return 1;
      if (a >= 16'h6000 && a < 16'h8000) return (SRAM != 0) ? 2 : 4;
      if (a >= 16'h8000) return 3;
      return 4;
   endfunction

   function automatic int key(input logic [15:0] a);
      if (a < 16'h2000) return int'(a) % (1 << RAW);
      if (a < 16'h8000) return 32'h20000 + int'(a) % 8192;
      return 32'h10000 + int'(a) % (BANKS * 16384);
   endfunction

   function automatic logic [15:0] wram_addr();
      return 16'(($urandom_range(0, 3) << 11) | (32'h100 + $urandom_range(0, 15)));
   endfunction

   function automatic logic [15:0] prg_addr();
      return 16'(32'h8000 | ($urandom_range(0, 1) << 14) | 32'h200 | $urandom_range(0, 15));
   endfunction

   always @(negedge clk) begin
      txn_t        t;
      logic [7:0]  e_dout;
      bit          e_busy, e_ack, e_inv, e_sel;
      if (chk_on) begin
         while (cur + 1 < tq.size() && tq[cur + 1].t_acc <= cyc) cur = cur + 1;
         if (cur < 0) begin
            e_busy = 0; e_ack = 0; e_inv = 0; e_sel = 0; e_dout = 8'h00;
         end else begin
            t      = tq[cur];
            e_busy = (cyc < t.t_ack);
            e_ack  = t.ack_exp && (cyc == t.t_ack);
            e_inv  = e_ack && t.inv;
            e_sel  = t.io && e_busy;
            e_dout = (cyc >= t.t_ack) ? t.dout_after : t.dout_before;
            if (e_sel) begin
               check("io_addr", io_addr, t.addr);
               check("io_wr", {15'd0, io_wr}, {15'd0, t.wr});
               if (t.wr) check("io_wdata", {8'd0, io_wdata}, {8'd0, t.wd});
            end
         end
         check("ack", {15'd0, ack}, {15'd0, e_ack});
         check("invalid_req", {15'd0, invalid_req}, {15'd0, e_inv});
         check("busy", {15'd0, busy}, {15'd0, e_busy});
         check("io_sel", {15'd0, io_sel}, {15'd0, e_sel});
         check("dout", {8'd0, dout}, {8'd0, e_dout});
      end
   end

   task automatic idle(input int n);
      req = 1'b0;
      repeat (n) begin
         io_ack   = 1'($urandom);
         io_rdata = 8'($urandom);
         @(negedge clk);
      end
      io_ack = 1'b0;
   endtask

   // lat: I/O cycle carrying io_ack (1..TMO), 0 or >TMO means never. rst_at >= 0 resets that many cycles after accept.
   task automatic do_txn(input bit w, input logic [15:0] a, input logic [7:0] d, input int lat,
                         input logic [7:0] rd, input bit drop, input int rst_at);
      txn_t t, r;
      int   k;
      k = region(a);
      t.t_acc = cyc + 1; t.ack_exp = 1'b1; t.inv = 1'b0; t.io = (k == 1);
      t.wr = w; t.addr = a; t.wd = d; t.dout_before = last_dout;
      if (k == 0 || k == 2 || k == 3) begin
         t.t_ack = t.t_acc + 1;
         if (w) begin
            t.dout_after = last_dout;
            if (rst_at < 0) mmem[key(a)] = d;
         end else begin
            t.dout_after = mmem[key(a)];
         end
      end else if (k == 1) begin
         if (lat >= 1 && lat <= TMO) begin
            t.t_ack = t.t_acc + lat;
            t.dout_after = w ? last_dout : rd;
         end else begin
            t.t_ack = t.t_acc + TMO; t.inv = 1'b1; t.dout_after = INV_D;
         end
      end else begin
         t.t_ack = t.t_acc; t.inv = 1'b1; t.dout_after = INV_D;
      end
      req = 1'b1; wr = w; addr = a; din = d;
      io_ack = 1'($urandom); io_rdata = 8'($urandom);
      tq.push_back(t);
      last_dout = (rst_at >= 0) ? 8'h00 : t.dout_after;
      @(negedge clk);
      if (drop && t.t_ack > t.t_acc) begin
         wr = 1'b1; addr = wram_addr(); din = 8'($urandom);
      end else begin
         req = 1'b0;
      end
      while (cyc < t.t_ack) begin
         if (rst_at >= 0 && cyc == t.t_acc + rst_at) begin
            rst = 1'b1; req = 1'b0; io_ack = 1'b0;
            r.t_acc = cyc + 1; r.t_ack = cyc + 1; r.ack_exp = 1'b0; r.inv = 1'b0; r.io = 1'b0;
            r.wr = 1'b0; r.addr = '0; r.wd = '0; r.dout_before = '0; r.dout_after = '0;
            tq.push_back(r);
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         if (t.io) begin
            io_ack   = (lat >= 1) && (cyc == t.t_acc + lat - 1);
            io_rdata = io_ack ? rd : 8'($urandom);
         end else begin
            io_ack   = 1'($urandom);
            io_rdata = 8'($urandom);
         end
         @(negedge clk);
         req = 1'b0;
      end
      req = 1'b0; io_ack = 1'b0;
   endtask

   task automatic expect_done(input string tag, input bit e_inv, input logic [7:0] e_d);
      check({tag, "_ack"}, {15'd0, ack}, 16'd1);
      check({tag, "_inv"}, {15'd0, invalid_req}, {15'd0, e_inv});
      check({tag, "_dout"}, {8'd0, dout}, {8'd0, e_d});
   endtask

   initial begin
      int          sel, s0;
      logic [15:0] a;
      rst = 1'b1; req = 1'b0; wr = 1'b0; addr = '0; din = '0; io_ack = 1'b0; io_rdata = '0;
      repeat (2) @(negedge clk);
      check("rst_dout", {8'd0, dout}, 16'h0000);
      check("rst_ack", {15'd0, ack}, 16'd0);
      check("rst_inv", {15'd0, invalid_req}, 16'd0);
      check("rst_busy", {15'd0, busy}, 16'd0);
      check("rst_io_sel", {15'd0, io_sel}, 16'd0);
      check("rst_io_wr", {15'd0, io_wr}, 16'd0);
      check("rst_io_addr", io_addr, 16'h0000);
      check("rst_io_wdata", {8'd0, io_wdata}, 16'h0000);
      rst = 1'b0;
      chk_on = 1'b1;

      for (int i = 0; i < 16; i++) begin
         do_txn(1'b1, 16'(32'h100 + i), 8'($urandom), 0, 8'h00, 1'b0, -1);
         do_txn(1'b1, 16'(32'h8200 + i), 8'($urandom), 0, 8'h00, 1'b0, -1);
         do_txn(1'b1, 16'(32'hC200 + i), 8'($urandom), 0, 8'h00, 1'b0, -1);
      end

      do_txn(1'b1, 16'h0005, 8'h3C, 0, 8'h00, 1'b0, -1);
      do_txn(1'b0, 16'h0805, 8'h00, 0, 8'h00, 1'b0, -1);
      expect_done("mirror0805", 1'b0, 8'h3C);
      do_txn(1'b0, 16'h1805, 8'h00, 0, 8'h00, 1'b0, -1);
      expect_done("mirror1805", 1'b0, 8'h3C);

      do_txn(1'b1, 16'hC123, 8'h11, 0, 8'h00, 1'b0, -1);
      do_txn(1'b1, 16'h8123, 8'hA5, 0, 8'h00, 1'b0, -1);
      do_txn(1'b0, 16'hC123, 8'h00, 0, 8'h00, 1'b0, -1);
      expect_done("prg_c123", 1'b0, 8'h11);
      do_txn(1'b0, 16'h8123, 8'h00, 0, 8'h00, 1'b0, -1);
      expect_done("prg_8123", 1'b0, 8'hA5);

      do_txn(1'b1, 16'h0500, 8'h77, 0, 8'h00, 1'b0, -1);
      do_txn(1'b1, 16'h0000, 8'h12, 0, 8'h00, 1'b0, -1);
      do_txn(1'b0, 16'h5000, 8'h00, 0, 8'h00, 1'b0, -1);
      expect_done("inv_rd5000", 1'b1, 8'hCD);
      do_txn(1'b1, 16'h4500, 8'hEE, 0, 8'h00, 1'b0, -1);
      expect_done("inv_wr4500", 1'b1, 8'hCD);
      do_txn(1'b1, 16'h6000, 8'hEE, 0, 8'h00, 1'b0, -1);
      expect_done("inv_wr6000", 1'b1, 8'hCD);
      do_txn(1'b0, 16'h0500, 8'h00, 0, 8'h00, 1'b0, -1);
      expect_done("keep_0500", 1'b0, 8'h77);
      do_txn(1'b0, 16'h0000, 8'h00, 0, 8'h00, 1'b0, -1);
      expect_done("keep_0000", 1'b0, 8'h12);
      do_txn(1'b0, 16'hE000, 8'h00, 0, 8'h00, 1'b0, -1);

      s0 = iosel_cnt;
      do_txn(1'b0, 16'h2002, 8'h00, 3, 8'h80, 1'b1, -1);
      expect_done("io_rd2002", 1'b0, 8'h80);
      check("io_sel_len3", 16'(iosel_cnt - s0), 16'd3);
      s0 = iosel_cnt;
      do_txn(1'b1, 16'h4016, 8'h01, 0, 8'h00, 1'b0, -1);
      expect_done("io_timeout", 1'b1, 8'hCD);
      check("io_sel_len15", 16'(iosel_cnt - s0), 16'd15);
      do_txn(1'b0, 16'h3000, 8'h00, 15, 8'h5A, 1'b0, -1);
      expect_done("io_ack_last", 1'b0, 8'h5A);

      do_txn(1'b1, 16'h0010, 8'h22, 0, 8'h00, 1'b0, -1);
      do_txn(1'b1, 16'h0010, 8'h55, 0, 8'h00, 1'b0, 0);
      check("rstmem_ack", {15'd0, ack}, 16'd0);
      check("rstmem_busy", {15'd0, busy}, 16'd0);
      do_txn(1'b0, 16'h2000, 8'h00, 0, 8'h00, 1'b0, 2);
      check("rstio_sel", {15'd0, io_sel}, 16'd0);
      check("rstio_ack", {15'd0, ack}, 16'd0);
      do_txn(1'b0, 16'h0010, 8'h00, 0, 8'h00, 1'b0, -1);
      expect_done("rst_keep_0010", 1'b0, 8'h22);
      do_txn(1'b0, 16'h0805, 8'h00, 0, 8'h00, 1'b0, -1);
      expect_done("b2b_0805", 1'b0, 8'h3C);
      do_txn(1'b0, 16'h8123, 8'h00, 0, 8'h00, 1'b0, -1);
      expect_done("b2b_8123", 1'b0, 8'hA5);

      for (int n = 0; n < 300; n++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0, 1, 2, 3: a = wram_addr();
            4, 5:       a = prg_addr();
            6:          a = 16'($urandom_range(32'h4020, 32'h7FFF));
            7, 8:       a = 16'($urandom_range(32'h2000, 32'h401F));
            default:    a = 16'h0000;
         endcase
         if (sel == 9) idle($urandom_range(1, 3));
         else do_txn(1'($urandom), a, 8'($urandom), $urandom_range(0, 17), 8'($urandom),
                     1'($urandom), -1);
      end
      idle(3);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
